// File: rtl/pc_gen_pkg.sv
// Shared fetch-pipeline constants: reset vector, PC-generator FSM encoding, instruction size.
package pc_gen_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_1000;
  localparam int unsigned INSN_BYTES       = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_shadow_pipe.sv
// Shadow pipeline carrying {pc, predicted successor, valid} from IF down to EX.
// Registered stages are 1..DEPTH-1; stage 0 is the live PC register owned by the parent.
module pc_shadow_pipe #(
  parameter int AW    = 32,
  parameter int DEPTH = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          kill_i,
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] prd_i,
  input  logic          vld_i,
  output logic [AW-1:0] id_pc_o,
  output logic          id_vld_o,
  output logic [AW-1:0] ex_pc_o,
  output logic [AW-1:0] ex_prd_o,
  output logic          ex_vld_o
);

  localparam int N = DEPTH - 1;

  logic [N-1:0][AW-1:0] pc_q;
  logic [N-1:0][AW-1:0] prd_q;
  logic [N-1:0]         vld_q;

  // A kill clears every valid bit on the same edge instead of letting them shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= '0;
      prd_q <= '0;
      vld_q <= '0;
    end else if (en_i) begin
      pc_q[0]  <= pc_i;
      prd_q[0] <= prd_i;
      vld_q[0] <= vld_i & ~kill_i;
      for (int s = 1; s < N; s++) begin
        pc_q[s]  <= pc_q[s-1];
        prd_q[s] <= prd_q[s-1];
        vld_q[s] <= vld_q[s-1] & ~kill_i;
      end
    end
  end

  assign id_pc_o  = pc_q[0];
  assign id_vld_o = vld_q[0];
  assign ex_pc_o  = pc_q[N-1];
  assign ex_prd_o = prd_q[N-1];
  assign ex_vld_o = vld_q[N-1];

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: registers the BHT next-fetch address, tracks flush/stall state,
// and feeds each fetched PC plus its predicted successor into the shadow pipe to EX.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF),
  parameter int                    DEPTH        = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic                  PRD_VALID,
  input  logic [ADDR_WIDTH-1:0] PRD_ADDR,
  input  logic                  FLUSH,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  FETCH_VALID,
  output logic [ADDR_WIDTH-1:0] ID_PC,
  output logic                  ID_VALID,
  output logic [ADDR_WIDTH-1:0] EX_PC,
  output logic [ADDR_WIDTH-1:0] EX_PRD_NEXT,
  output logic                  EX_VALID,
  output logic [31:0]           FETCH_COUNT,
  output logic [31:0]           FLUSH_COUNT
);

  pc_state_e             state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  fv_q;
  logic                  pend_q;
  logic [31:0]           fetch_cnt_q;
  logic [31:0]           flush_cnt_q;

  logic                  en;
  logic                  kill;
  logic [ADDR_WIDTH-1:0] prd_al;
  logic [ADDR_WIDTH-1:0] next_pc_d;
  logic [ADDR_WIDTH-1:0] pc_d;

  assign en = CACHE_READY & CACHE_READY_DATA;

  // A flush seen during a stall is remembered in pend_q and applied on the first enabled edge.
  always_comb begin
    prd_al    = {PRD_ADDR[ADDR_WIDTH-1:2], 2'b00};
    next_pc_d = PRD_VALID ? prd_al : pc_q + ADDR_WIDTH'(INSN_BYTES);
    kill      = en & (FLUSH | pend_q);
    pc_d      = pc_q;
    if (kill)                pc_d = prd_al;
    else if (state_q != BOOT) pc_d = next_pc_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      fv_q        <= 1'b0;
      pend_q      <= 1'b0;
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!en) begin
      if (FLUSH) begin
        pend_q  <= 1'b1;
        state_q <= HOLD;
      end
    end else begin
      pc_q    <= pc_d;
      fv_q    <= 1'b1;
      pend_q  <= 1'b0;
      state_q <= RUN;
      if (fv_q) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (kill) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  pc_shadow_pipe #(
    .AW    (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_shadow (
    .clk_i    (CLK),
    .rst_i    (RST),
    .en_i     (en),
    .kill_i   (kill),
    .pc_i     (pc_q),
    .prd_i    (next_pc_d),
    .vld_i    (fv_q),
    .id_pc_o  (ID_PC),
    .id_vld_o (ID_VALID),
    .ex_pc_o  (EX_PC),
    .ex_prd_o (EX_PRD_NEXT),
    .ex_vld_o (EX_VALID)
  );

  assign PC          = pc_q;
  assign FETCH_VALID = fv_q;
  assign FETCH_COUNT = fetch_cnt_q;
  assign FLUSH_COUNT = flush_cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector bench for pc_gen (DEPTH=3): table-driven stream plus a wrap-around sequence.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, CACHE_READY, CACHE_READY_DATA, PRD_VALID, FLUSH;
  logic [31:0] PRD_ADDR;
  logic [31:0] PC, ID_PC, EX_PC, EX_PRD_NEXT, FETCH_COUNT, FLUSH_COUNT;
  logic        FETCH_VALID, ID_VALID, EX_VALID;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0000_1000), .DEPTH(3)) dut (
    .CLK(CLK), .RST(RST), .CACHE_READY(CACHE_READY), .CACHE_READY_DATA(CACHE_READY_DATA),
    .PRD_VALID(PRD_VALID), .PRD_ADDR(PRD_ADDR), .FLUSH(FLUSH),
    .PC(PC), .FETCH_VALID(FETCH_VALID), .ID_PC(ID_PC), .ID_VALID(ID_VALID),
    .EX_PC(EX_PC), .EX_PRD_NEXT(EX_PRD_NEXT), .EX_VALID(EX_VALID),
    .FETCH_COUNT(FETCH_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
  );

  typedef struct {
    logic        rst, cr, crd, pv;
    logic [31:0] pa;
    logic        fl;
    logic [31:0] pc;
    logic        fv, idv;
    logic [31:0] idpc;
    logic        exv;
    logic [31:0] expc, exprd, fc, flc;
    logic [1:0]  st;
    logic        pend;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [1:0] SB = 2'd0, SR = 2'd1, SH = 2'd2;

  vec_t tv [22];

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic rst, cr, crd, pv, input logic [31:0] pa, input logic fl);
    @(negedge CLK);
    RST = rst; CACHE_READY = cr; CACHE_READY_DATA = crd; PRD_VALID = pv; PRD_ADDR = pa; FLUSH = fl;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; CACHE_READY = 1'b1; CACHE_READY_DATA = 1'b1;
    PRD_VALID = 1'b0; PRD_ADDR = '0; FLUSH = 1'b0;

    //         rst cr crd pv pa            fl | pc            fv idv idpc          exv expc          exprd         fc  flc st  pend
    tv[0]  = '{H, H, H, L, 32'h0,        L, 32'h1000,     L, L, 32'h0,        L, 32'h0,        32'h0,        0,  0, SB, L};
    tv[1]  = '{L, H, H, L, 32'h0,        L, 32'h1000,     H, L, 32'h1000,     L, 32'h0,        32'h0,        0,  0, SR, L};
    tv[2]  = '{L, H, H, L, 32'h0,        L, 32'h1004,     H, H, 32'h1000,     L, 32'h1000,     32'h1004,     1,  0, SR, L};
    tv[3]  = '{L, H, H, L, 32'h0,        L, 32'h1008,     H, H, 32'h1004,     H, 32'h1000,     32'h1004,     2,  0, SR, L};
    tv[4]  = '{L, H, H, H, 32'h2000,     L, 32'h2000,     H, H, 32'h1008,     H, 32'h1004,     32'h1008,     3,  0, SR, L};
    tv[5]  = '{L, H, H, L, 32'h0,        L, 32'h2004,     H, H, 32'h2000,     H, 32'h1008,     32'h2000,     4,  0, SR, L};
    for (int i = 6; i <= 10; i++)
      tv[i] = '{L, L, H, H, 32'h5550,    L, 32'h2004,     H, H, 32'h2000,     H, 32'h1008,     32'h2000,     4,  0, SR, L};
    tv[11] = '{L, H, H, L, 32'h0,        L, 32'h2008,     H, H, 32'h2004,     H, 32'h2000,     32'h2004,     5,  0, SR, L};
    tv[12] = '{L, H, H, H, 32'h3002,     H, 32'h3000,     H, L, 32'h2008,     L, 32'h2004,     32'h2008,     6,  1, SR, L};
    tv[13] = '{L, H, H, L, 32'h0,        L, 32'h3004,     H, H, 32'h3000,     L, 32'h2008,     32'h3000,     7,  1, SR, L};
    tv[14] = '{L, H, H, L, 32'h0,        L, 32'h3008,     H, H, 32'h3004,     H, 32'h3000,     32'h3004,     8,  1, SR, L};
    tv[15] = '{L, H, L, L, 32'h0,        H, 32'h3008,     H, H, 32'h3004,     H, 32'h3000,     32'h3004,     8,  1, SH, H};
    tv[16] = '{L, H, L, L, 32'h0,        L, 32'h3008,     H, H, 32'h3004,     H, 32'h3000,     32'h3004,     8,  1, SH, H};
    tv[17] = '{L, H, L, L, 32'h0,        H, 32'h3008,     H, H, 32'h3004,     H, 32'h3000,     32'h3004,     8,  1, SH, H};
    tv[18] = '{L, H, H, H, 32'h4000,     L, 32'h4000,     H, L, 32'h3008,     L, 32'h3004,     32'h3008,     9,  2, SR, L};
    tv[19] = '{L, H, H, L, 32'h0,        L, 32'h4004,     H, H, 32'h4000,     L, 32'h3008,     32'h4000,     10, 2, SR, L};
    tv[20] = '{L, H, L, L, 32'h0,        H, 32'h4004,     H, H, 32'h4000,     L, 32'h3008,     32'h4000,     10, 2, SH, H};
    tv[21] = '{H, H, L, L, 32'h0,        H, 32'h1000,     L, L, 32'h0,        L, 32'h0,        32'h0,        0,  0, SB, L};

    for (int i = 0; i < 22; i++) begin
      drive(tv[i].rst, tv[i].cr, tv[i].crd, tv[i].pv, tv[i].pa, tv[i].fl);
      chk("PC",          i, PC,                  tv[i].pc);
      chk("FETCH_VALID", i, 32'(FETCH_VALID),    32'(tv[i].fv));
      chk("ID_VALID",    i, 32'(ID_VALID),       32'(tv[i].idv));
      chk("ID_PC",       i, ID_PC,               tv[i].idpc);
      chk("EX_VALID",    i, 32'(EX_VALID),       32'(tv[i].exv));
      chk("EX_PC",       i, EX_PC,               tv[i].expc);
      chk("EX_PRD_NEXT", i, EX_PRD_NEXT,         tv[i].exprd);
      chk("FETCH_COUNT", i, FETCH_COUNT,         tv[i].fc);
      chk("FLUSH_COUNT", i, FLUSH_COUNT,         tv[i].flc);
      chk("state",       i, 32'(dut.state_q),    32'(tv[i].st));
      chk("pend_flush",  i, 32'(dut.pend_q),     32'(tv[i].pend));
    end

    // Address wrap: prediction to the top word, then sequential fallback rolls over to 0.
    drive(L, H, H, L, 32'h0, L);
    chk("wrap boot PC",  100, PC, 32'h1000);
    drive(L, H, H, H, 32'hFFFF_FFFF, L);
    chk("wrap top PC",   101, PC, 32'hFFFF_FFFC);
    drive(L, H, H, L, 32'h0, L);
    chk("wrap PC",       102, PC, 32'h0);
    chk("wrap FC",       102, FETCH_COUNT, 32'd2);
    drive(L, H, H, L, 32'h0, L);
    chk("wrap next PC",  103, PC, 32'h4);
    chk("wrap EX_PC",    103, EX_PC, 32'hFFFF_FFFC);
    chk("wrap EX_PRD",   103, EX_PRD_NEXT, 32'h0);
    chk("wrap EX_VALID", 103, 32'(EX_VALID), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
